csr_access_ctrl: RTL and testbench

Sequencer for Zicsr instructions in the RISC-V core. It accepts one CSR instruction at a time over a valid/ready handshake and runs the read-modify-write against the CSR register file (CSRRW/RS/RC and their immediate forms). It applies read-only and illegal-opcode checks, and serves `misa` locally as a WARL constant. It sits between decode/execute and the CSR file, and returns the old CSR value for write-back to rd.

---
 rtl/csr_access_ctrl.sv | 133 +++++++++++++
 tb/tb_csr_access_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: Zicsr read-modify-write sequencer.
// Serves misa locally; flags illegal/read-only writes.
module csr_access_ctrl #(
  parameter logic [31:0] MISA_VALUE = 32'h4000_0100,
  parameter logic [11:0] MISA_ADDR  = 12'h301
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic [11:0] csr_addr_in,
  input  logic [2:0]  csr_op_in,
  input  logic [31:0] rs1_data_in,
  input  logic        rs1_zero_in,
  input  logic [4:0]  uimm_in,
  output logic        csr_rd_en_out,
  output logic [11:0] csr_addr_out,
  input  logic [31:0] csr_rdata_in,
  output logic        csr_wr_en_out,
  output logic [31:0] csr_wdata_out,
  output logic        resp_valid_out,
  output logic [31:0] resp_rdata_out,
  output logic        resp_illegal_out,
  input  logic        resp_ready_in
);

  typedef enum logic [2:0] {
    IDLE, READ, LATCH, WRITE, RESP
  } state_t;

  state_t      state;
  logic [11:0] addr_q;
  logic [1:0]  op_q;
  logic [31:0] src_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        ill_q;

  logic [31:0] src;
  logic        src_zero;
  logic        wr_intent;
  logic        illegal;
  logic        is_misa;
  logic [31:0] new_val;
  logic        busy;

  // Decode the incoming request before it is registered
  always_comb begin
    src = csr_op_in[2] ? {27'b0, uimm_in}
                       : rs1_data_in;
    src_zero = csr_op_in[2] ? (uimm_in == 5'd0)
                            : rs1_zero_in;
    wr_intent = (csr_op_in[1:0] == 2'b01)
              | ~src_zero;
    illegal = (csr_op_in[1:0] == 2'b00)
            | (wr_intent
               & (csr_addr_in[11:10] == 2'b11));
    is_misa = (csr_addr_in == MISA_ADDR);
  end

  // Modified value from the captured operands
  always_comb begin
    new_val = src_q;
    unique case (1'b1)
      op_q == 2'b10: new_val = csr_rdata_in | src_q;
      op_q == 2'b11: new_val = csr_rdata_in & ~src_q;
      default:       new_val = src_q;
    endcase
  end

  // Sequencer state and all registered datapath
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state   <= IDLE;
      addr_q  <= '0;
      op_q    <= '0;
      src_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      ill_q   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid_in) begin
            addr_q <= csr_addr_in;
            op_q   <= csr_op_in[1:0];
            src_q  <= src;
            wr_q   <= wr_intent;
            if (illegal) begin
              ill_q   <= 1'b1;
              rdata_q <= '0;
              state   <= RESP;
            end else if (is_misa) begin
              ill_q   <= 1'b0;
              rdata_q <= MISA_VALUE;
              state   <= RESP;
            end else begin
              ill_q <= 1'b0;
              state <= READ;
            end
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          rdata_q <= csr_rdata_in;
          wdata_q <= new_val;
          state   <= WRITE;
        end
        WRITE: state <= RESP;
        RESP: begin
          if (resp_ready_in) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == READ)
              | (state == LATCH)
              | (state == WRITE);

  assign req_ready_out    = (state == IDLE) & ~rst_in;
  assign csr_rd_en_out    = (state == READ);
  assign csr_addr_out     = busy ? addr_q : '0;
  assign csr_wr_en_out    = (state == WRITE) & wr_q;
  assign csr_wdata_out    = csr_wr_en_out ? wdata_q : '0;
  assign resp_valid_out   = (state == RESP);
  assign resp_rdata_out   = resp_valid_out ? rdata_q : '0;
  assign resp_illegal_out = resp_valid_out & ill_q;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// tb_csr_access_ctrl: scoreboard bench for the
// CSR access sequencer with a small CSR file model.
module tb_csr_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [11:0] csr_addr_in;
  logic [2:0]  csr_op_in;
  logic [31:0] rs1_data_in;
  logic        rs1_zero_in;
  logic [4:0]  uimm_in;
  logic        csr_rd_en_out;
  logic [11:0] csr_addr_out;
  logic [31:0] csr_rdata_in;
  logic        csr_wr_en_out;
  logic [31:0] csr_wdata_out;
  logic        resp_valid_out;
  logic [31:0] resp_rdata_out;
  logic        resp_illegal_out;
  logic        resp_ready_in;

  always #5 clk = ~clk;

  csr_access_ctrl dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .csr_addr_in      (csr_addr_in),
    .csr_op_in        (csr_op_in),
    .rs1_data_in      (rs1_data_in),
    .rs1_zero_in      (rs1_zero_in),
    .uimm_in          (uimm_in),
    .csr_rd_en_out    (csr_rd_en_out),
    .csr_addr_out     (csr_addr_out),
    .csr_rdata_in     (csr_rdata_in),
    .csr_wr_en_out    (csr_wr_en_out),
    .csr_wdata_out    (csr_wdata_out),
    .resp_valid_out   (resp_valid_out),
    .resp_rdata_out   (resp_rdata_out),
    .resp_illegal_out (resp_illegal_out),
    .resp_ready_in    (resp_ready_in)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc, rd_cyc, wr_cyc, resp_cyc;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int hs_cnt = 0;
  logic        prev_rv = 1'b0;
  logic [11:0] exp_addr = '0;
  logic [31:0] file_val = '0;
  logic [32:0] resp_q[$];
  logic [43:0] wr_q[$];
  logic [32:0] r_exp;
  logic [43:0] w_exp;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h",
               nm, act, exp);
    end
  endtask

  // CSR file model: data valid the cycle after rd_en
  always @(posedge clk)
    csr_rdata_in <= csr_rd_en_out ? file_val
                                  : 32'hDEAD_BEEF;

  // Monitor: strobes, timing marks, response scoreboard
  always @(negedge clk) begin
    cyc++;
    if (req_valid_in && req_ready_out) acc_cyc = cyc;
    if (csr_rd_en_out) begin
      rd_cnt++;
      rd_cyc = cyc;
      chk("rd_addr", {20'b0, csr_addr_out},
          {20'b0, exp_addr});
    end
    if (csr_wr_en_out) begin
      wr_cnt++;
      wr_cyc = cyc;
      if (wr_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_wr actual=%h required=none",
                 csr_wdata_out);
      end else begin
        w_exp = wr_q.pop_front();
        chk("wr_addr", {20'b0, csr_addr_out},
            {20'b0, w_exp[43:32]});
        chk("wdata", csr_wdata_out, w_exp[31:0]);
      end
    end
    if (resp_valid_out && !prev_rv) resp_cyc = cyc;
    prev_rv = resp_valid_out;
    if (resp_valid_out && resp_ready_in) begin
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp actual=%h required=none",
                 resp_rdata_out);
      end else begin
        r_exp = resp_q.pop_front();
        chk("resp_rdata", resp_rdata_out, r_exp[32:1]);
        chk("resp_illegal", {31'b0, resp_illegal_out},
            {31'b0, r_exp[0]});
      end
      hs_cnt++;
    end
  end

  task automatic run(input logic [11:0] a,
                     input logic [2:0]  op,
                     input logic [31:0] rs1,
                     input logic        rz,
                     input logic [4:0]  ui,
                     input logic [31:0] fv,
                     input logic [31:0] er,
                     input logic        ei,
                     input logic        erd,
                     input logic        ewr,
                     input logic [31:0] ewd,
                     input int          hold);
    int start_hs;
    int t;
    logic [31:0] snap;
    file_val = fv;
    exp_addr = a;
    rd_cnt = 0;
    wr_cnt = 0;
    rd_cyc = -100;
    wr_cyc = -100;
    resp_cyc = -100;
    acc_cyc = -200;
    resp_q.push_back({er, ei});
    if (ewr) wr_q.push_back({a, ewd});
    start_hs = hs_cnt;
    @(posedge clk); #1;
    chk("ready_idle", {31'b0, req_ready_out}, 32'd1);
    csr_addr_in   = a;
    csr_op_in     = op;
    rs1_data_in   = rs1;
    rs1_zero_in   = rz;
    uimm_in       = ui;
    req_valid_in  = 1'b1;
    resp_ready_in = (hold == 0);
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    csr_addr_in  = 12'hABC;
    csr_op_in    = 3'b011;
    rs1_data_in  = $urandom;
    rs1_zero_in  = ~rz;
    uimm_in      = 5'h1F;
    if (hold > 0) begin
      t = 0;
      while (!resp_valid_out && t < 20) begin
        @(negedge clk);
        t++;
      end
      snap = resp_rdata_out;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_valid", {31'b0, resp_valid_out}, 32'd1);
        chk("bp_rdata", resp_rdata_out, snap);
        chk("bp_ready", {31'b0, req_ready_out}, 32'd0);
      end
      @(posedge clk); #1;
      resp_ready_in = 1'b1;
    end
    t = 0;
    while (hs_cnt == start_hs && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("resp_seen", {31'b0, hs_cnt != start_hs}, 32'd1);
    @(posedge clk); #1;
    chk("ready_after", {31'b0, req_ready_out}, 32'd1);
    chk("rd_count", rd_cnt, {31'b0, erd});
    chk("wr_count", wr_cnt, {31'b0, ewr});
    if (erd) chk("rd_lat", rd_cyc - acc_cyc, 32'd1);
    if (ewr) chk("wr_lat", wr_cyc - acc_cyc, 32'd3);
    chk("resp_lat", resp_cyc - acc_cyc,
        erd ? 32'd4 : 32'd1);
  endtask

  task automatic chk_zero_out(input string nm);
    chk({nm, "_rd"}, {31'b0, csr_rd_en_out}, 32'd0);
    chk({nm, "_wr"}, {31'b0, csr_wr_en_out}, 32'd0);
    chk({nm, "_addr"}, {20'b0, csr_addr_out}, 32'd0);
    chk({nm, "_wdata"}, csr_wdata_out, 32'd0);
    chk({nm, "_rv"}, {31'b0, resp_valid_out}, 32'd0);
    chk({nm, "_rdata"}, resp_rdata_out, 32'd0);
    chk({nm, "_ill"}, {31'b0, resp_illegal_out}, 32'd0);
  endtask

  task automatic rst_mid(input logic at_latch);
    int t;
    file_val = 32'h5555_AAAA;
    exp_addr = 12'h340;
    wr_cnt = 0;
    @(posedge clk); #1;
    csr_addr_in  = 12'h340;
    csr_op_in    = 3'b001;
    rs1_data_in  = 32'h1357_9BDF;
    rs1_zero_in  = 1'b0;
    req_valid_in = 1'b1;
    @(posedge clk); #1;
    req_valid_in = 1'b0;
    t = 0;
    while (!csr_rd_en_out && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("rst_reached_read", {31'b0, csr_rd_en_out}, 32'd1);
    if (at_latch) begin
      @(posedge clk); #2;
    end else begin
      #2;
    end
    rst_in = 1'b1;
    #1;
    chk_zero_out(at_latch ? "rstL" : "rstR");
    chk("rst_ready", {31'b0, req_ready_out}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_in = 1'b0;
    @(posedge clk); #1;
    chk("rst_ready_after", {31'b0, req_ready_out}, 32'd1);
    repeat (6) @(posedge clk);
    #1;
    chk("rst_no_wr", wr_cnt, 32'd0);
  endtask

  initial begin
    rst_in        = 1'b1;
    req_valid_in  = 1'b0;
    csr_addr_in   = '0;
    csr_op_in     = '0;
    rs1_data_in   = '0;
    rs1_zero_in   = 1'b0;
    uimm_in       = '0;
    resp_ready_in = 1'b1;
    #1;
    chk("ready_in_reset", {31'b0, req_ready_out}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_in = 1'b0;
    @(posedge clk); #1;
    chk_zero_out("reset");
    chk("reset_ready", {31'b0, req_ready_out}, 32'd1);

    // CSRRS 0x340: 0x0F | 0xF0
    run(12'h340, 3'b010, 32'h0000_00F0, 1'b0, 5'd0,
        32'h0000_000F, 32'h0000_000F, 1'b0,
        1'b1, 1'b1, 32'h0000_00FF, 0);
    // CSRRCI 0x300 uimm 0: read only
    run(12'h300, 3'b111, 32'hFFFF_FFFF, 1'b0, 5'd0,
        32'h1234_5678, 32'h1234_5678, 1'b0,
        1'b1, 1'b0, 32'h0, 0);
    // CSRRWI 0x300 uimm 0: writes 0
    run(12'h300, 3'b101, 32'hFFFF_FFFF, 1'b0, 5'd0,
        32'hAAAA_5555, 32'hAAAA_5555, 1'b0,
        1'b1, 1'b1, 32'h0, 0);
    // CSRRW misa: local constant, write dropped
    run(12'h301, 3'b001, 32'hFFFF_FFFF, 1'b0, 5'd0,
        32'h0BAD_0BAD, 32'h4000_0100, 1'b0,
        1'b0, 1'b0, 32'h0, 0);
    // CSRRW 0xC00: read-only write
    run(12'hC00, 3'b001, 32'h0000_0001, 1'b0, 5'd0,
        32'h0BAD_0BAD, 32'h0, 1'b1,
        1'b0, 1'b0, 32'h0, 0);
    // CSRRS 0xC00 rs1=x0: legal read
    run(12'hC00, 3'b010, 32'hFFFF_0000, 1'b1, 5'd0,
        32'hC0FF_EE00, 32'hC0FF_EE00, 1'b0,
        1'b1, 1'b0, 32'h0, 0);
    // CSRRS 0xC00 rs1!=x0: illegal
    run(12'hC00, 3'b010, 32'h0, 1'b0, 5'd0,
        32'h0BAD_0BAD, 32'h0, 1'b1,
        1'b0, 1'b0, 32'h0, 0);
    // funct3 100 and 000 illegal
    run(12'h340, 3'b100, 32'h0, 1'b0, 5'd3,
        32'h0BAD_0BAD, 32'h0, 1'b1,
        1'b0, 1'b0, 32'h0, 0);
    run(12'h340, 3'b000, 32'h0, 1'b0, 5'd3,
        32'h0BAD_0BAD, 32'h0, 1'b1,
        1'b0, 1'b0, 32'h0, 0);
    // CSRRC with 5 cycles of backpressure
    run(12'h305, 3'b011, 32'h0000_FF00, 1'b0, 5'd0,
        32'h1234_5678, 32'h1234_5678, 1'b0,
        1'b1, 1'b1, 32'h1234_0078, 5);
    // CSRRSI 0x344 uimm 0x15
    run(12'h344, 3'b110, 32'hFFFF_FFFF, 1'b0, 5'h15,
        32'h0000_0100, 32'h0000_0100, 1'b0,
        1'b1, 1'b1, 32'h0000_0115, 0);
    // misa with backpressure
    run(12'h301, 3'b010, 32'h0, 1'b1, 5'd0,
        32'h0BAD_0BAD, 32'h4000_0100, 1'b0,
        1'b0, 1'b0, 32'h0, 5);

    rst_mid(1'b0);
    rst_mid(1'b1);

    // Normal operation resumes after reset
    run(12'h340, 3'b001, 32'hCAFE_F00D, 1'b0, 5'd0,
        32'h0000_0042, 32'h0000_0042, 1'b0,
        1'b1, 1'b1, 32'hCAFE_F00D, 0);

    repeat (5) @(posedge clk);
    #1;
    chk("resp_q_empty", resp_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
